key_schedule: RTL and testbench
===============================

// Module: key_schedule
// PURPOSE
//  SIMON32/64 key expansion for the iterative datapath; sits directly upstream of the round function.
//  Loads a 64-bit master key and presents one 16-bit round key per round.
//  Four 16-bit key words are held in a shift register; the next key word is generated on the fly.
//  The round controller consumes one key per advance.
// PARAMETERS
//  ROUNDS  32                 number of round keys produced (SIMON32/64 = 32)
//  Z_SEQ   62'h3E8958737D12B0E6  z0 constant; Z_SEQ[61] = z bit 0 (leftmost bit of the published z0 string)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   synchronous reset, active-low
//  key_in      in   64  master key {k3,k2,k1,k0}; k0 = key_in[15:0] is the round-0 key
//  load        in   1   capture key_in and start a new schedule (single-cycle pulse)
//  advance     in   1   current round key consumed; step to the next round
//  round_key   out  16  key for round round_idx, driven from register
//  round_idx   out  5   index of the round key currently presented, 0..ROUNDS-1
//  key_valid   out  1   round_key/round_idx are meaningful
//  done        out  1   one-cycle pulse after the final key is consumed
// BEHAVIOUR
//  Reset (rst_n=0 at edge): key regs kr0..kr3=0, round_idx=0, key_valid=0, done=0, FSM=IDLE.
//  FSM states:
//   - IDLE: key_valid=0.
//   - ACTIVE: key_valid=1.
//   - No other states; done is a registered pulse.
//  load at edge N (any state):
//   - kr0..kr3 <= key_in[15:0],[31:16],[47:32],[63:48].
//   - round_idx <= 0, key_valid <= 1, state <= ACTIVE.
//   - After edge N: round_key = key_in[15:0]. Latency 1 clock, no bubble.
//  advance in ACTIVE with round_idx < ROUNDS-1:
//   - Shift: kr0<=kr1, kr1<=kr2, kr2<=kr3, kr3<=knew.
//   - round_idx <= round_idx+1.
//  knew generation, with i = round_idx:
//   - tmp = ROR3(kr3) ^ kr1
//   - tmp = tmp ^ ROR1(tmp)
//   - knew = kr0 ^ tmp ^ 16'hFFFC ^ {15'b0, z}
//   - z = Z_SEQ[61-i]
//   - All arithmetic is 16-bit XOR/rotate; there is no carry.
//  advance in ACTIVE with round_idx == ROUNDS-1:
//   - key_valid <= 0, done <= 1 for exactly one cycle, state <= IDLE.
//   - round_idx holds its value; key regs hold their values.
//  advance in IDLE is ignored; done stays 0.
//  advance low: all outputs hold (stall of any length).
//  load and advance on the same edge: load wins; the advance is dropped.
//  load during ACTIVE: restart from round 0 with the new key; no done pulse.
//  load on the same edge as the final advance: restart wins; done stays 0.
//  rst_n low mid-schedule: returns to reset values at that edge; reset has priority over load.
//  round_idx never wraps; it never exceeds ROUNDS-1.
//  Z_SEQ index never exceeds ROUNDS-1 (<62); no mod-62 wrap is needed for SIMON32/64.
// TESTING
//  T1:
//   - Stimulus: load key_in=64'h1918_1110_0908_0100, then advance every cycle.
//   - Response: round_key = 0100, 0908, 1110, 1918, 71C3 at round_idx 0..4.
//  T2:
//   - Stimulus: key as T1, chained with round_function; pt = 32'h6565_6877; 32 advances.
//   - Response: ct = 32'hC69B_E9BB; done high exactly one cycle after the 32nd advance; key_valid=0.
//  T3:
//   - Stimulus: key as T1; advance low for 10 cycles at round_idx=3.
//   - Response: round_key holds 1918; round_idx holds 3; no done.
//  T4:
//   - Stimulus: load a new key at round_idx=17, asserting advance in the same cycle.
//   - Response: round_idx=0 and round_key = new key_in[15:0] on the next cycle; no done pulse.
//  T5:
//   - Stimulus: rst_n=0 for one edge at round_idx=9.
//   - Response: all outputs 0; subsequent advance pulses are ignored until the next load.
//  T6:
//   - Stimulus: advance pulses in IDLE after done.
//   - Response: key_valid, done and round_idx unchanged.

Source files
------------

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - SIMON32/64 round-key generator for the iterative datapath
//
// Holds the four most recent 16-bit key words in a shift register (kr0 is the
// key presented for the current round) and derives the next word on the fly
// whenever the round controller consumes a key.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   key_in     64-bit master key {k3,k2,k1,k0}; k0 is the round-0 key
//   load       capture key_in and restart at round 0
//   advance    current round key consumed; step to the next round
//   round_key  key for round round_idx (registered)
//   round_idx  index of the presented key, 0..ROUNDS-1
//   key_valid  round_key/round_idx are meaningful
//   done       one-cycle pulse after the final key is consumed

module key_schedule #(
  parameter int          ROUNDS = 32,
  parameter logic [61:0] Z_SEQ  = 62'h3E8958737D12B0E6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] round_key,
  output logic [4:0]  round_idx,
  output logic        key_valid,
  output logic        done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

  state_t      state;
  logic [15:0] kr0, kr1, kr2, kr3;
  logic [15:0] tmp_a, tmp_b, knew;
  logic [5:0]  z_idx;
  logic        z_bit;

  function automatic logic [15:0] ror(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  // Z_SEQ[61] holds z bit 0, so round i draws from bit 61-i.
  always_comb begin
    z_idx = 6'd61 - {1'b0, round_idx};
    z_bit = Z_SEQ[z_idx];
    tmp_a = ror(kr3, 3) ^ kr1;
    tmp_b = tmp_a ^ ror(tmp_a, 1);
    // 16'hFFFC folds the bitwise inversion of kr0 and the constant 3 together.
    knew  = kr0 ^ tmp_b ^ 16'hFFFC ^ {15'b0, z_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      kr0       <= '0;
      kr1       <= '0;
      kr2       <= '0;
      kr3       <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // Load has priority over advance, including the final advance.
        kr0       <= key_in[15:0];
        kr1       <= key_in[31:16];
        kr2       <= key_in[47:32];
        kr3       <= key_in[63:48];
        round_idx <= '0;
        key_valid <= 1'b1;
        state     <= ACTIVE;
      end else if (advance && state == ACTIVE) begin
        if (round_idx == LAST_IDX) begin
          key_valid <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end else begin
          kr0       <= kr1;
          kr1       <= kr2;
          kr2       <= kr3;
          kr3       <= knew;
          round_idx <= round_idx + 5'd1;
        end
      end
    end
  end

  assign round_key = kr0;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule

module tb_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        load;
  logic        advance;
  logic [15:0] round_key;
  logic [4:0]  round_idx;
  logic        key_valid;
  logic        done;

  int total = 0;
  int bad   = 0;

  key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .load      (load),
    .advance   (advance),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [15:0] mk [32];
  logic [15:0] seen [32];
  logic [61:0] zc = 62'h3E8958737D12B0E6;

  function automatic logic [15:0] rr(input logic [15:0] x, input int r);
    return (x >> r) | (x << (16 - r));
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] x, input int r);
    return (x << r) | (x >> (16 - r));
  endfunction

  // Reference key expansion in the textbook form: k[i+4] = ~k[i] ^ tmp ^ z[i] ^ 3.
  task automatic expand(input logic [63:0] key);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) mk[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rr(mk[i-1], 3) ^ mk[i-3];
      t = t ^ rr(t, 1);
      mk[i] = ~mk[i-4] ^ t ^ 16'd3 ^ {15'b0, zc[61-(i-4)]};
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] k, input int idx,
                         input logic v, input logic d);
    chk({tag, ".key"},   64'(round_key), 64'(k));
    chk({tag, ".idx"},   64'(round_idx), 64'(idx));
    chk({tag, ".valid"}, 64'(key_valid), 64'(v));
    chk({tag, ".done"},  64'(done),      64'(d));
  endtask

  task automatic do_load(input logic [63:0] k);
    key_in = k; load = 1'b1; advance = 1'b0;
    step();
    load = 1'b0;
    expand(k);
  endtask

  task automatic adv_n(input int n, input int start);
    advance = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step();
      chk_all("walk", mk[start+i], start + i, 1'b1, 1'b0);
    end
    advance = 1'b0;
  endtask

  initial begin
    logic [15:0] x, y, t;
    logic [63:0] k2;
    int e_idx;
    logic e_act;

    rst_n = 1'b0; load = 1'b0; advance = 1'b0; key_in = '0;
    step(); step();
    chk_all("reset", 16'h0000, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // T1/T2: full schedule of the published vector
    do_load(64'h1918_1110_0908_0100);
    chk_all("t1.load", 16'h0100, 0, 1'b1, 1'b0);
    seen[0] = round_key;
    advance = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step();
      seen[i] = round_key;
      chk_all("t1.round", mk[i], i, 1'b1, 1'b0);
      if (i == 4) chk("t1.k4", 64'(round_key), 64'h71C3);
    end
    step();
    chk_all("t2.final", mk[31], 31, 1'b0, 1'b1);
    advance = 1'b0;
    step();
    chk("t2.done_pulse", 64'(done), 64'd0);
    x = 16'h6565; y = 16'h6877;
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ seen[i];
      y = t;
    end
    chk("t2.ct", {32'h0, x, y}, 64'hC69B_E9BB);

    // T6: advance in IDLE is ignored
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6.valid", 64'(key_valid), 64'd0);
      chk("t6.done",  64'(done),      64'd0);
      chk("t6.idx",   64'(round_idx), 64'd31);
    end
    advance = 1'b0;

    // T3: stall at round 3
    do_load(64'h1918_1110_0908_0100);
    adv_n(3, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("t3.stall", 16'h1918, 3, 1'b1, 1'b0);
    end

    // T4: reload at round 17 with a concurrent advance
    do_load({$urandom, $urandom});
    adv_n(17, 0);
    k2 = {$urandom, $urandom};
    key_in = k2; load = 1'b1; advance = 1'b1;
    step();
    load = 1'b0; advance = 1'b0;
    expand(k2);
    chk_all("t4.reload", k2[15:0], 0, 1'b1, 1'b0);
    step();
    chk_all("t4.after", k2[15:0], 0, 1'b1, 1'b0);

    // Load on the same edge as the final advance: restart, no done
    adv_n(31, 0);
    k2 = {$urandom, $urandom};
    key_in = k2; load = 1'b1; advance = 1'b1;
    step();
    load = 1'b0; advance = 1'b0;
    expand(k2);
    chk_all("last.reload", k2[15:0], 0, 1'b1, 1'b0);

    // T5: reset at round 9
    adv_n(9, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all("t5.reset", 16'h0000, 0, 1'b0, 1'b0);
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("t5.ignored", 16'h0000, 0, 1'b0, 1'b0);
    end
    advance = 1'b0;

    // Random keys with random advance/stall pattern against the model
    for (int n = 0; n < 4; n++) begin
      do_load({$urandom, $urandom});
      e_idx = 0; e_act = 1'b1;
      for (int c = 0; c < 60; c++) begin
        advance = ($urandom_range(0, 3) != 0);
        step();
        if (advance && e_act) begin
          if (e_idx == 31) begin
            e_act = 1'b0;
            chk_all("rnd.end", mk[31], 31, 1'b0, 1'b1);
          end else begin
            e_idx++;
            chk_all("rnd.adv", mk[e_idx], e_idx, 1'b1, 1'b0);
          end
        end else begin
          chk_all("rnd.hold", mk[e_idx], e_idx, e_act, 1'b0);
        end
      end
      advance = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
